// File: rtl/compute_seq.sv
// compute_seq: per-element transform r = 2*in1 + in0 + (in0 even ? 3 : -1),
// accumulated over a sequence of up to LEN elements (or until in_last),
// then presented as sum / max / count on a valid-ready output port.
module compute_seq #(
  parameter int WIDTH = 8,
  parameter int LEN   = 4,
  parameter int CW    = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_max,
  output logic [CW-1:0]    out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept_s;
  logic [WIDTH-1:0] r_s;

  // Per-element result; every term is WIDTH bits so all additions wrap.
  function automatic logic [WIDTH-1:0] elem_r(input logic [WIDTH-1:0] a0,
                                              input logic [WIDTH-1:0] a1);
    logic [WIDTH-1:0] dbl;
    logic [WIDTH-1:0] adj;
    dbl = a1 << 1;
    adj = a0[0] ? {WIDTH{1'b1}} : WIDTH'(3);
    return dbl + a0 + adj;
  endfunction

  assign r_s      = elem_r(in0, in1);
  assign accept_s = in_valid && (state_q != HOLD);

  // Outputs decode directly from registered state, so they are glitch-free.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;

  // Next-state and datapath update for the accumulate / hold sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          acc_d = r_s;
          max_d = r_s;
          cnt_d = CW'(1);
          if (in_last || (LEN == 1)) begin
            state_d = HOLD;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (accept_s) begin
          acc_d = acc_q + r_s;
          max_d = (r_s > max_q) ? r_s : max_q;
          cnt_d = cnt_q + CW'(1);
          // cnt_q + 1 reaching LEN forces HOLD, so cnt never exceeds LEN.
          if (in_last || ((cnt_q + CW'(1)) == CW'(LEN))) begin
            state_d = HOLD;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        max_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and accumulator registers; reset discards any partial or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_compute_seq.sv
// Self-checking bench for compute_seq: directed scenarios plus random traffic,
// scoreboard queues filled by the stimulus side and drained by output monitors.
module tb_compute_seq;

  localparam int W   = 8;
  localparam int L   = 4;
  localparam int WB  = 4;
  localparam int LB  = 1;
  localparam int CWA = $clog2(L + 1);
  localparam int CWB = $clog2(LB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, in_ready, in_last, out_valid, out_ready;
  logic [W-1:0]   in0, in1, out_sum, out_max;
  logic [CWA-1:0] out_count;

  logic           b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic [WB-1:0]  b_in0, b_in1, b_out_sum, b_out_max;
  logic [CWB-1:0] b_out_count;

  compute_seq #(.WIDTH(W), .LEN(L)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_max(out_max), .out_count(out_count)
  );

  compute_seq #(.WIDTH(WB), .LEN(LB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in0(b_in0), .in1(b_in1), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum), .out_max(b_out_max), .out_count(b_out_count)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {int sum; int mx; int cnt;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // Reference model state for the sequence currently being built on dut_a.
  int cur_sum = 0, cur_max = 0, cur_cnt = 0;

  bit rand_mode   = 1'b0;
  bit ready_fixed = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // r from the arithmetic definition, reduced modulo 2^w.
  function automatic int model_r(input int w, input int a0, input int a1);
    return (2 * a1 + a0 + (((a0 % 2) == 0) ? 3 : -1)) % (1 << w);
  endfunction

  task automatic model_a(input int a0, input int a1, input bit last, output bit closed);
    int r;
    r = model_r(W, a0, a1);
    cur_cnt++;
    cur_sum = (cur_sum + r) % (1 << W);
    if (cur_cnt == 1 || r > cur_max) cur_max = r;
    closed = last || (cur_cnt == L);
    if (closed) begin
      qa.push_back('{cur_sum, cur_max, cur_cnt});
      cur_sum = 0; cur_max = 0; cur_cnt = 0;
    end
  endtask

  // Sink readiness: random or fixed, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one element to dut_a; caller is at posedge+1, returns at posedge+1.
  task automatic send_a(input int a0, input int a1, input bit last);
    bit done = 1'b0;
    bit closed;
    in_valid = 1'b1; in0 = a0[W-1:0]; in1 = a1[W-1:0]; in_last = last;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) begin
      chk("accept_timeout", 64'(done), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_a(a0, a1, last, closed);
    #1;
    in_valid = 1'b0; in0 = W'($urandom); in1 = W'($urandom); in_last = 1'($urandom);
    if (closed) begin
      @(negedge clk);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_b(input int a0, input int a1);
    bit done = 1'b0;
    int r;
    b_in_valid = 1'b1; b_in0 = a0[WB-1:0]; b_in1 = a1[WB-1:0]; b_in_last = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (b_in_ready) done = 1'b1;
    end
    if (!done) begin
      chk("b_accept_timeout", 64'(done), 64'd1);
      b_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    r = model_r(WB, a0, a1);
    qb.push_back('{r, r, 1});
    #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_latency_out_valid", 64'(b_out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // dut_a output monitor: stability in HOLD, handshake scoreboard, post-handshake readiness.
  logic           prev_v, hs_prev;
  logic [W-1:0]   ps, pm;
  logic [CWA-1:0] pc;
  always @(negedge clk) begin
    if (rst) begin
      prev_v  <= 1'b0;
      hs_prev <= 1'b0;
    end else begin
      if (hs_prev) begin
        chk("post_hs_out_valid_low", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready_high", 64'(in_ready), 64'd1);
      end else if (out_valid) begin
        chk("hold_in_ready_low", 64'(in_ready), 64'd0);
        if (prev_v) begin
          chk("stable_sum", 64'(out_sum), 64'(ps));
          chk("stable_max", 64'(out_max), 64'(pm));
          chk("stable_count", 64'(out_count), 64'(pc));
        end
        if (out_ready) begin
          if (qa.size() == 0) begin
            chk("spurious_result_queue_size", 64'(qa.size()), 64'd1);
          end else begin
            ea = qa.pop_front();
            chk("out_sum", 64'(out_sum), 64'(ea.sum));
            chk("out_max", 64'(out_max), 64'(ea.mx));
            chk("out_count", 64'(out_count), 64'(ea.cnt));
          end
        end
      end
      prev_v  <= out_valid && !out_ready && !hs_prev;
      hs_prev <= out_valid && out_ready && !hs_prev;
      ps <= out_sum; pm <= out_max; pc <= out_count;
    end
  end

  // dut_b output monitor (sink always ready, so each valid cycle is one result).
  always @(negedge clk) begin
    if (!rst && b_out_valid) begin
      chk("b_hold_in_ready_low", 64'(b_in_ready), 64'd0);
      if (qb.size() == 0) begin
        chk("b_spurious_result_queue_size", 64'(qb.size()), 64'd1);
      end else begin
        eb = qb.pop_front();
        chk("b_out_sum", 64'(b_out_sum), 64'(eb.sum));
        chk("b_out_max", 64'(b_out_max), 64'(eb.mx));
        chk("b_out_count", 64'(b_out_count), 64'(eb.cnt));
      end
    end
  end

  initial begin
    int s1a0 [4] = '{4, 5, 0, 1};
    int s1a1 [4] = '{3, 3, 0, 0};
    rst = 1'b1;
    in_valid = 1'b0; in0 = '0; in1 = '0; in_last = 1'b0;
    b_in_valid = 1'b0; b_in0 = '0; b_in1 = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_max", 64'(out_max), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;

    // Full sequence, in_valid held high.
    for (int i = 0; i < 4; i++) send_a(s1a0[i], s1a1[i], 1'b0);
    idle(2);
    // Early end with a single element.
    send_a(0, 0, 1'b1);
    send_a(1, 0, 1'b1);
    // Wrap-around.
    repeat (4) send_a(255, 255, 1'b0);
    send_a(254, 255, 1'b1);
    // Gaps between elements.
    for (int i = 0; i < 4; i++) begin
      send_a(s1a0[i], s1a1[i], 1'b0);
      idle(2);
    end
    // Output backpressure with a held in_valid that must wait for HOLD to end.
    ready_fixed = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) send_a(s1a0[i], s1a1[i], 1'b0);
    fork
      send_a(0, 0, 1'b1);
      begin
        repeat (6) @(posedge clk);
        ready_fixed = 1'b1;
      end
    join
    idle(3);
    // Reset mid-sequence discards the partial result.
    send_a(4, 3, 1'b0);
    send_a(5, 3, 1'b0);
    rst = 1'b1;
    cur_sum = 0; cur_max = 0; cur_cnt = 0;
    #2;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    chk("midrst_out_max", 64'(out_max), 64'd0);
    chk("midrst_out_count", 64'(out_count), 64'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_no_result", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send_a(0, 0, 1'b1);

    // Random traffic with random sink readiness and gaps.
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send_a(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_mode = 1'b0;
    ready_fixed = 1'b1;

    // WIDTH=4, LEN=1 instance: HOLD without in_last.
    send_b(15, 15);
    for (int i = 0; i < 10; i++) begin
      send_b(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 0) idle(1);
    end

    for (int k = 0; k < 100 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
    idle(2);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
